// File: rtl/hls_macc_nc_result_fifo_if.sv
// Bundle of core handshake, result stream and accumulator signals for
// hls_macc_nc_result_fifo. master = the FIFO block, slave = its environment.
interface hls_macc_nc_result_fifo_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 32
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic            run;
  logic            core_start;
  logic            core_done;
  logic [DW-1:0]   o1;
  logic [DW-1:0]   o2;
  logic            o1_ap_vld;
  logic            o2_ap_vld;
  logic [2*DW-1:0] m_data;
  logic            m_valid;
  logic            m_ready;
  logic [CW-1:0]   count;
  logic            err;
  logic            acc_clr;
  logic [DW-1:0]   acc1;
  logic [DW-1:0]   acc2;

  modport master (
    input  run, core_done, o1, o2, o1_ap_vld, o2_ap_vld, m_ready, acc_clr,
    output core_start, m_data, m_valid, count, err, acc1, acc2
  );

  modport slave (
    output run, core_done, o1, o2, o1_ap_vld, o2_ap_vld, m_ready, acc_clr,
    input  core_start, m_data, m_valid, count, err, acc1, acc2
  );
endinterface

// File: rtl/hls_macc_nc_result_fifo.sv
// Launches an HLS core with ap_start/ap_done, buffers its {o2,o1} results in a
// first-word-fall-through FIFO and reserves a slot per launch so the FIFO can
// never overflow. Optional running accumulators: define HLS_MACC_NC_ACC_EN.
module hls_macc_nc_result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 32
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst,
  hls_macc_nc_result_fifo_if.master     bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;

  state_t          state;
  logic            resv;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   n_stored;
  logic [2*DW-1:0] mem [DEPTH];

  logic            both_vld;
  logic            push;
  logic            pop;
  logic            bad;
  logic            rel_resv;
  logic            launch;
  logic [CW-1:0]   cnt_after;
  logic [PW-1:0]   rd_ptr_next;
  logic [CW-1:0]   n_stored_next;
  logic [2*DW-1:0] push_data;
  logic [2*DW-1:0] head_next;

  // Handshake decode, launch decision and next head-of-queue selection
  always_comb begin
    both_vld      = bus.o1_ap_vld & bus.o2_ap_vld;
    push          = both_vld && (state == S_WAIT) && resv;
    bad           = (bus.o1_ap_vld ^ bus.o2_ap_vld) || (both_vld && !push);
    pop           = bus.m_valid && bus.m_ready;
    // a core that finishes without results gives its reservation back
    rel_resv      = (state == S_WAIT) && bus.core_done && resv && !push;
    cnt_after     = bus.count - CW'(rel_resv) - CW'(pop);
    launch        = 1'b0;
    unique case (state)
      S_IDLE:  launch = bus.run && (bus.count < CW'(DEPTH));
      S_WAIT:  launch = bus.core_done && bus.run && (cnt_after < CW'(DEPTH));
      default: launch = 1'b0;
    endcase
    push_data     = {bus.o2, bus.o1};
    rd_ptr_next   = rd_ptr + PW'(pop);
    n_stored_next = n_stored + CW'(push) - CW'(pop);
    head_next     = '0;
    if (n_stored_next != '0) begin
      if (push && (rd_ptr_next == wr_ptr)) head_next = push_data;
      else                                 head_next = mem[rd_ptr_next];
    end
  end

  // Control FSM, occupancy bookkeeping and registered outputs
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state          <= S_IDLE;
      resv           <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      n_stored       <= '0;
      bus.core_start <= 1'b0;
      bus.count      <= '0;
      bus.m_valid    <= 1'b0;
      bus.m_data     <= '0;
      bus.err        <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (launch) begin
            state          <= S_LAUNCH;
            bus.core_start <= 1'b1;
          end
        end
        S_LAUNCH: state <= S_WAIT;
        S_WAIT: begin
          if (bus.core_done) begin
            if (launch) begin
              state <= S_LAUNCH;
            end else begin
              state          <= S_IDLE;
              bus.core_start <= 1'b0;
            end
          end
        end
        default: begin
          state          <= S_IDLE;
          bus.core_start <= 1'b0;
        end
      endcase

      if (launch)                resv <= 1'b1;
      else if (push || rel_resv) resv <= 1'b0;

      wr_ptr      <= wr_ptr + PW'(push);
      rd_ptr      <= rd_ptr_next;
      n_stored    <= n_stored_next;
      bus.count   <= bus.count + CW'(launch) - CW'(rel_resv) - CW'(pop);
      bus.m_valid <= (n_stored_next != '0);
      bus.m_data  <= head_next;
      bus.err     <= bus.err | bad;
    end
  end

  // Result storage; contents are don't-care until written
  always_ff @(posedge ap_clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

`ifdef HLS_MACC_NC_ACC_EN
  // Running sums of accepted results; a clear coinciding with a push loads it
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      bus.acc1 <= '0;
      bus.acc2 <= '0;
    end else if (bus.acc_clr) begin
      bus.acc1 <= push ? bus.o1 : '0;
      bus.acc2 <= push ? bus.o2 : '0;
    end else if (push) begin
      bus.acc1 <= bus.acc1 + bus.o1;
      bus.acc2 <= bus.acc2 + bus.o2;
    end
  end
`else
  // Accumulators disabled: tie off and ignore the clear
  assign bus.acc1 = '0;
  assign bus.acc2 = '0;
  logic unused_acc_clr;
  assign unused_acc_clr = bus.acc_clr;
`endif
endmodule

// File: tb/tb_hls_macc_nc_result_fifo.sv
// Directed bench for hls_macc_nc_result_fifo (DEPTH=4, DW=32): a vector table
// for the basic launch/push/pop flow plus hand sequences for fill/drain,
// protocol errors, asynchronous reset and the optional accumulators.
module tb_hls_macc_nc_result_fifo;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 32;
`ifdef HLS_MACC_NC_ACC_EN
  localparam bit ACC_ON = 1'b1;
`else
  localparam bit ACC_ON = 1'b0;
`endif

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  always #5 ap_clk = ~ap_clk;

  hls_macc_nc_result_fifo_if #(.DEPTH(DEPTH), .DW(DW)) bus ();

  hls_macc_nc_result_fifo #(.DEPTH(DEPTH), .DW(DW)) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  typedef struct {
    logic        run, done, v1, v2, rdy;
    logic [31:0] o1, o2;
    logic        exp_cs, exp_mv;
    logic [63:0] exp_data;
    logic [2:0]  exp_cnt;
    logic        exp_err;
  } vec_t;

  vec_t tbl [7];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic drive(input logic run, input logic done, input logic v1, input logic v2,
                       input logic rdy, input logic [31:0] o1, input logic [31:0] o2);
    bus.run = run; bus.core_done = done; bus.o1_ap_vld = v1; bus.o2_ap_vld = v2;
    bus.m_ready = rdy; bus.o1 = o1; bus.o2 = o2;
  endtask

  task automatic chk_acc(input string name, input logic [31:0] e1, input logic [31:0] e2);
    chk({name, "_acc1"}, 64'(bus.acc1), ACC_ON ? 64'(e1) : 64'h0);
    chk({name, "_acc2"}, 64'(bus.acc2), ACC_ON ? 64'(e2) : 64'h0);
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_cs"},    64'(bus.core_start), 64'h0);
    chk({name, "_count"}, 64'(bus.count),      64'h0);
    chk({name, "_mv"},    64'(bus.m_valid),    64'h0);
    chk({name, "_data"},  bus.m_data,          64'h0);
    chk({name, "_err"},   64'(bus.err),        64'h0);
    chk_acc(name, 32'h0, 32'h0);
  endtask

  task automatic pulse_reset();
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
  endtask

  logic [31:0] d1 [4];
  logic [31:0] d2 [4];

  initial begin
    // run, done, v1, v2, rdy, o1, o2 | cs, mv, data, count, err
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,  1'b1, 1'b0, 64'h0, 3'd1, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,  1'b1, 1'b0, 64'h0, 3'd1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h5,  32'h7,  1'b1, 1'b1, 64'h00000007_00000005, 3'd2, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  32'h0,  1'b1, 1'b0, 64'h0, 3'd1, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h11, 32'h22, 1'b0, 1'b1, 64'h00000022_00000011, 3'd1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  32'h0,  1'b0, 1'b0, 64'h0, 3'd0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,  1'b0, 1'b0, 64'h0, 3'd0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      d1[i] = 32'h100 + 32'(i);
      d2[i] = 32'hA000 + 32'(i);
    end

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.acc_clr = 1'b0;
    #12;
    chk_reset_vals("reset");
    @(negedge ap_clk);
    ap_rst = 1'b0;
    tick();

    // basic launch / push / pop flow
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].run, tbl[i].done, tbl[i].v1, tbl[i].v2, tbl[i].rdy, tbl[i].o1, tbl[i].o2);
      tick();
      chk($sformatf("vec%0d_cs", i),    64'(bus.core_start), 64'(tbl[i].exp_cs));
      chk($sformatf("vec%0d_mv", i),    64'(bus.m_valid),    64'(tbl[i].exp_mv));
      chk($sformatf("vec%0d_data", i),  bus.m_data,          tbl[i].exp_data);
      chk($sformatf("vec%0d_count", i), 64'(bus.count),      64'(tbl[i].exp_cnt));
      chk($sformatf("vec%0d_err", i),   64'(bus.err),        64'(tbl[i].exp_err));
    end

    // fill with m_ready low: four launches, then the block stalls
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("fill%0d_wait_cs", i),    64'(bus.core_start), 64'h1);
      chk($sformatf("fill%0d_wait_count", i), 64'(bus.count),      64'(i + 1));
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, d1[i], d2[i]);
      tick();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk($sformatf("fill%0d_cs", i),    64'(bus.core_start), (i < 3) ? 64'h1 : 64'h0);
      chk($sformatf("fill%0d_count", i), 64'(bus.count),      (i < 3) ? 64'(i + 2) : 64'h4);
      chk($sformatf("fill%0d_head", i),  bus.m_data,          {d2[0], d1[0]});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("full_hold%0d_cs", i),    64'(bus.core_start), 64'h0);
      chk($sformatf("full_hold%0d_count", i), 64'(bus.count),      64'h4);
    end

    // drain in order; relaunch two cycles after the first pop
    bus.m_ready = 1'b1;
    tick();
    chk("drain1_data", bus.m_data, {d2[1], d1[1]});
    chk("drain1_count", 64'(bus.count), 64'h3);
    chk("drain1_cs", 64'(bus.core_start), 64'h0);
    tick();
    chk("drain2_data", bus.m_data, {d2[2], d1[2]});
    chk("drain2_count", 64'(bus.count), 64'h3);
    chk("drain2_cs", 64'(bus.core_start), 64'h1);
    tick();
    chk("drain3_data", bus.m_data, {d2[3], d1[3]});
    chk("drain3_count", 64'(bus.count), 64'h2);
    tick();
    chk("drain4_mv", 64'(bus.m_valid), 64'h0);
    chk("drain4_data", bus.m_data, 64'h0);
    chk("drain4_count", 64'(bus.count), 64'h1);
    chk("drain4_cs", 64'(bus.core_start), 64'h1);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hAA, 32'hBB);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    chk("last_push_cs", 64'(bus.core_start), 64'h0);
    chk("last_push_data", bus.m_data, 64'h000000BB_000000AA);
    chk("last_push_count", 64'(bus.count), 64'h1);
    tick();
    chk("last_pop_count", 64'(bus.count), 64'h0);
    chk("last_pop_mv", 64'(bus.m_valid), 64'h0);

    // two stored entries plus a reservation, then async reset mid-cycle
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1, 32'h2);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h3, 32'h4);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("pre_rst_count", 64'(bus.count), 64'h3);
    chk("pre_rst_data", bus.m_data, 64'h00000002_00000001);
    #2;
    ap_rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    ap_rst = 1'b0;
    tick();
    chk_reset_vals("post_rst");

    // both valids while idle: error, nothing stored
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h55, 32'h66);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("idle_push_err", 64'(bus.err), 64'h1);
    chk("idle_push_count", 64'(bus.count), 64'h0);
    chk("idle_push_mv", 64'(bus.m_valid), 64'h0);
    chk("idle_push_data", bus.m_data, 64'h0);
    tick();
    tick();
    chk("idle_push_err_sticky", 64'(bus.err), 64'h1);
    pulse_reset();
    tick();
    chk("err_cleared", 64'(bus.err), 64'h0);

    // single valid while waiting: error, reservation intact
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    bus.run = 1'b0;
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h77, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("one_vld_err", 64'(bus.err), 64'h1);
    chk("one_vld_count", 64'(bus.count), 64'h1);
    chk("one_vld_mv", 64'(bus.m_valid), 64'h0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h8, 32'h9);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    chk("one_vld_then_push_data", bus.m_data, 64'h00000009_00000008);
    chk("one_vld_err_sticky", 64'(bus.err), 64'h1);
    tick();
    chk("one_vld_drain_count", 64'(bus.count), 64'h0);
    chk("one_vld_err_sticky2", 64'(bus.err), 64'h1);
    pulse_reset();
    tick();

    // accumulators: wrap, clear, clear coinciding with a push
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    tick();
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    chk_acc("acc_first", 32'hFFFF_FFFF, 32'h1);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1, 32'h2);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    chk_acc("acc_wrap", 32'h0, 32'h3);
    tick();
    bus.acc_clr = 1'b1;
    tick();
    bus.acc_clr = 1'b0;
    chk_acc("acc_clr", 32'h0, 32'h0);
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h4, 32'h5);
    bus.acc_clr = 1'b1;
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    bus.acc_clr = 1'b0;
    chk_acc("acc_clr_push", 32'h4, 32'h5);
    chk("acc_err_clean", 64'(bus.err), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
